// File: rtl/cache_ctrl_plru.sv
// Set-associative cache controller: tag/valid/dirty state, hit detection, writeback/fill sequencing and PLRU strobes.
// Optional macro CACHE_INVALID_FIRST_EN: a miss picks the lowest invalid way before falling back to plru_lru.
module cache_ctrl_plru #(
    parameter int ways_bits = 2,
    parameter int s_index   = 3,
    parameter int s_offset  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_read,
    input  logic                 cpu_write,
    input  logic [31:0]          cpu_address,
    output logic                 cpu_resp,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [31:0]          mem_address,
    input  logic                 mem_resp,
    output logic [s_index-1:0]   plru_set,
    output logic                 plru_load,
    output logic [ways_bits-1:0] plru_access,
    input  logic [ways_bits-1:0] plru_lru,
    output logic [s_index-1:0]   data_set,
    output logic [ways_bits-1:0] data_way,
    output logic                 data_we,
    output logic                 fill_we
);
    localparam int WAYS  = 1 << ways_bits;
    localparam int SETS  = 1 << s_index;
    localparam int TAG_W = 32 - s_index - s_offset;

    typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, FILL} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [31-s_offset:0]  r_line;
    logic                  r_write;
    logic [ways_bits-1:0]  r_victim;
    logic [TAG_W-1:0]      r_tag   [SETS][WAYS];
    logic [WAYS-1:0]       r_valid [SETS];
    logic [WAYS-1:0]       r_dirty [SETS];

    logic [s_index-1:0]    w_index;
    logic [TAG_W-1:0]      w_reqTag;
    logic                  w_hit;
    logic [ways_bits-1:0]  w_hitWay;
    logic [ways_bits-1:0]  w_victim;
    logic                  w_unusedOffset;

    // Only the line address is latched; byte offset bits never reach the controller state.
    assign w_index        = r_line[s_index-1:0];
    assign w_reqTag       = r_line[31-s_offset -: TAG_W];
    assign w_unusedOffset = ^cpu_address[s_offset-1:0];
    assign plru_set       = (r_state == IDLE) ? cpu_address[s_offset +: s_index] : w_index;
    assign data_set       = plru_set;

    always_comb begin
        w_hit    = 1'b0;
        w_hitWay = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w_index][w] && (r_tag[w_index][w] == w_reqTag)) begin
                w_hit    = 1'b1;
                w_hitWay = ways_bits'(w);
            end
        end
    end

`ifdef CACHE_INVALID_FIRST_EN
    // Descending scan so the lowest-numbered invalid way wins.
    always_comb begin
        w_victim = plru_lru;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w_index][w]) begin
                w_victim = ways_bits'(w);
            end
        end
    end
`else
    always_comb begin
        w_victim = plru_lru;
    end
`endif

    always_comb begin
        w_next      = r_state;
        cpu_resp    = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        plru_load   = 1'b0;
        plru_access = '0;
        data_way    = '0;
        data_we     = 1'b0;
        fill_we     = 1'b0;
        case (r_state)
            IDLE: begin
                if (cpu_read || cpu_write) begin
                    w_next = COMPARE;
                end
            end
            COMPARE: begin
                if (w_hit) begin
                    cpu_resp    = 1'b1;
                    plru_load   = 1'b1;
                    plru_access = w_hitWay;
                    data_way    = w_hitWay;
                    data_we     = r_write;
                    w_next      = IDLE;
                end else if (r_valid[w_index][w_victim] && r_dirty[w_index][w_victim]) begin
                    w_next = WRITEBACK;
                end else begin
                    w_next = FILL;
                end
            end
            WRITEBACK: begin
                mem_write   = 1'b1;
                mem_address = {r_tag[w_index][r_victim], w_index, {s_offset{1'b0}}};
                data_way    = r_victim;
                if (mem_resp) begin
                    w_next = FILL;
                end
            end
            FILL: begin
                mem_read    = 1'b1;
                mem_address = {r_line, {s_offset{1'b0}}};
                data_way    = r_victim;
                if (mem_resp) begin
                    fill_we = 1'b1;
                    w_next  = COMPARE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_line   <= '0;
            r_write  <= 1'b0;
            r_victim <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
            end
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (cpu_read || cpu_write) begin
                        r_line  <= cpu_address[31:s_offset];
                        r_write <= cpu_write;
                    end
                end
                COMPARE: begin
                    if (w_hit) begin
                        if (r_write) begin
                            r_dirty[w_index][w_hitWay] <= 1'b1;
                        end
                    end else begin
                        r_victim <= w_victim;
                    end
                end
                WRITEBACK: begin
                    if (mem_resp) begin
                        r_dirty[w_index][r_victim] <= 1'b0;
                    end
                end
                FILL: begin
                    if (mem_resp) begin
                        r_valid[w_index][r_victim] <= 1'b1;
                        r_dirty[w_index][r_victim] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tags are deliberately left out of reset; valid bits alone gate hits.
    always_ff @(posedge clk) begin
        if (!rst && (r_state == FILL) && mem_resp) begin
            r_tag[w_index][r_victim] <= w_reqTag;
        end
    end

endmodule
